mem_arb: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory port of the RV32E core. Instruction fetch (IFU) and load/store (LSU) both issue requests with a valid/ready handshake. The block grants one at a time and drives a single outstanding transaction to memory. It then routes the response back to the owner as a one-cycle pulse. It replaces the fixed three-phase fetch/execute schedule, so memory may take any number of cycles.

---
 rtl/mem_arb_pkg.sv | 36 +++
 rtl/mem_arb_if.sv | 57 +++++
 rtl/mem_arb_timeout.sv | 28 ++
 rtl/mem_arb.sv | 136 +++++++++++++
 tb/tb_mem_arb.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, bus width,
// reset polarity and the latched request record.
package mem_arb_pkg;

  localparam int unsigned REG_BUS = 32;
  localparam logic        RST_VAL = 1'b1;

  typedef logic [REG_BUS-1:0] reg_bus_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic       wen;
    reg_bus_t   addr;
    reg_bus_t   wdata;
    logic [7:0] wmask;
    logic [2:0] rmask;
  } mem_req_t;

  // Instruction fetches are always full-word reads.
  function automatic mem_req_t fetch_req(input reg_bus_t addr);
    mem_req_t r;
    r.wen   = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.wmask = '0;
    r.rmask = 3'b111;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of IFU, LSU and memory-side handshake signals of mem_arb.
// slave = arbiter view, master = surrounding core/memory view.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic       ifu_req_valid;
  logic       ifu_req_ready;
  reg_bus_t   ifu_addr;
  logic       ifu_resp_valid;
  reg_bus_t   ifu_rdata;
  logic       ifu_resp_err;

  logic       lsu_req_valid;
  logic       lsu_req_ready;
  logic       lsu_wen;
  reg_bus_t   lsu_addr;
  reg_bus_t   lsu_wdata;
  logic [7:0] lsu_wmask;
  logic [2:0] lsu_rmask;
  logic       lsu_resp_valid;
  reg_bus_t   lsu_rdata;
  logic       lsu_resp_err;

  logic       mem_req_valid;
  logic       mem_req_ready;
  logic       mem_wen;
  reg_bus_t   mem_addr;
  reg_bus_t   mem_wdata;
  logic [7:0] mem_wmask;
  logic [2:0] mem_rmask;
  logic       mem_resp_valid;
  reg_bus_t   mem_rdata;

  logic       busy;
  logic       owner_lsu;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output busy, owner_lsu
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_rmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, mem_rmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  busy, owner_lsu
  );

endinterface

// File: rtl/mem_arb_timeout.sv
// REQ+WAIT watchdog for mem_arb: cleared on grant, counts while a transaction
// is in flight, flags expiry in the TIMEOUT_CYCLES-th cycle.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/mem_arb.sv
// IFU/LSU arbiter and single-outstanding sequencer for the shared memory port.
// Optional transaction timeout enabled by defining ARB_TIMEOUT_EN.
module mem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_W       = 8
) (
  input  logic    clk,
  input  logic    rst,
  mem_arb_if.slave bus
);
  import mem_arb_pkg::*;

  arb_state_e state;
  mem_req_t   req_q;
  logic       rst_on;
  logic       grant_lsu, grant_ifu;
  logic       done, expire, abort, finish;
  logic       mem_req_valid_q, busy_q, owner_lsu_q;
  logic       ifu_resp_valid_q, lsu_resp_valid_q;
  logic       ifu_resp_err_q, lsu_resp_err_q;
  reg_bus_t   ifu_rdata_q, lsu_rdata_q;

  assign rst_on = (rst == RST_VAL);

  // Acceptance is combinational so a requester sees ready in the cycle it is granted.
  always_comb begin
    grant_lsu = 1'b0;
    grant_ifu = 1'b0;
    if (state == ARB_IDLE && !rst_on) begin
      grant_lsu = bus.lsu_req_valid;
      grant_ifu = !bus.lsu_req_valid && bus.ifu_req_valid;
    end
  end

  assign done = (state == ARB_REQ  && bus.mem_req_ready && bus.mem_resp_valid) ||
                (state == ARB_WAIT && bus.mem_resp_valid);

`ifdef ARB_TIMEOUT_EN
  mem_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst_on),
    .clear  (grant_lsu || grant_ifu),
    .run    (state == ARB_REQ || state == ARB_WAIT),
    .expire (expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, TO_CNT_W};
  assign expire     = 1'b0;
`endif

  // A completion in the same cycle as expiry takes precedence over the abort.
  assign abort  = expire && !done;
  assign finish = done || abort;

  always_ff @(posedge clk) begin
    if (rst_on) begin
      state            <= ARB_IDLE;
      req_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      busy_q           <= 1'b0;
      owner_lsu_q      <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_err_q   <= 1'b0;
      ifu_rdata_q      <= '0;
      lsu_rdata_q      <= '0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_err_q   <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (grant_lsu || grant_ifu) begin
            req_q           <= grant_lsu ? mem_req_t'{wen:   bus.lsu_wen,
                                                      addr:  bus.lsu_addr,
                                                      wdata: bus.lsu_wdata,
                                                      wmask: bus.lsu_wmask,
                                                      rmask: bus.lsu_rmask}
                                         : fetch_req(bus.ifu_addr);
            owner_lsu_q     <= grant_lsu;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state           <= ARB_REQ;
          end
        end
        ARB_REQ, ARB_WAIT: begin
          if (finish) begin
            mem_req_valid_q <= 1'b0;
            state           <= ARB_RESP;
            if (owner_lsu_q) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_resp_err_q   <= !done;
              lsu_rdata_q      <= done ? bus.mem_rdata : '0;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_resp_err_q   <= !done;
              ifu_rdata_q      <= done ? bus.mem_rdata : '0;
            end
          end else if (state == ARB_REQ && bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= ARB_WAIT;
          end
        end
        ARB_RESP: begin
          busy_q <= 1'b0;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_wen        = req_q.wen;
  assign bus.mem_addr       = req_q.addr;
  assign bus.mem_wdata      = req_q.wdata;
  assign bus.mem_wmask      = req_q.wmask;
  assign bus.mem_rmask      = req_q.rmask;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.busy           = busy_q;
  assign bus.owner_lsu      = owner_lsu_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: per-cycle vector table plus hand sequences for
// stall, reset-in-WAIT and timeout (ARB_TIMEOUT_EN) behaviour.
module tb_mem_arb;

  localparam int unsigned TO = 8;
  localparam logic [31:0] A1 = 32'h8000_0000;
  localparam logic [31:0] A2 = 32'h8000_0004;
  localparam logic [31:0] AL = 32'h8000_2000;
  localparam logic [31:0] AS = 32'h8000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arb_if bus();

  mem_arb #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic ifu_v; logic [31:0] ifu_addr;
    logic lsu_v; logic lsu_wen; logic [31:0] lsu_addr; logic [31:0] lsu_wdata;
    logic [7:0] lsu_wmask; logic [2:0] lsu_rmask;
    logic mrdy; logic mresp; logic [31:0] mrdata;
    logic e_ifu_rdy; logic e_lsu_rdy; logic e_mvalid; logic e_mwen;
    logic [31:0] e_maddr; logic [31:0] e_mwdata; logic [7:0] e_mwmask; logic [2:0] e_mrmask;
    logic e_ifu_rv; logic [31:0] e_ifu_rd; logic e_lsu_rv; logic [31:0] e_lsu_rd;
    logic e_busy; logic e_own;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0; bus.ifu_addr  = '0;
    bus.lsu_req_valid  = 1'b0; bus.lsu_wen   = 1'b0; bus.lsu_addr = '0;
    bus.lsu_wdata      = '0;   bus.lsu_wmask = '0;   bus.lsu_rmask = '0;
    bus.mem_req_ready  = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic apply(input vec_t v);
    bus.ifu_req_valid  = v.ifu_v;   bus.ifu_addr  = v.ifu_addr;
    bus.lsu_req_valid  = v.lsu_v;   bus.lsu_wen   = v.lsu_wen;   bus.lsu_addr  = v.lsu_addr;
    bus.lsu_wdata      = v.lsu_wdata; bus.lsu_wmask = v.lsu_wmask; bus.lsu_rmask = v.lsu_rmask;
    bus.mem_req_ready  = v.mrdy;    bus.mem_resp_valid = v.mresp; bus.mem_rdata = v.mrdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("row%0d ifu_req_ready", i),  32'(bus.ifu_req_ready),  32'(v.e_ifu_rdy));
    chk($sformatf("row%0d lsu_req_ready", i),  32'(bus.lsu_req_ready),  32'(v.e_lsu_rdy));
    chk($sformatf("row%0d mem_req_valid", i),  32'(bus.mem_req_valid),  32'(v.e_mvalid));
    chk($sformatf("row%0d mem_wen", i),        32'(bus.mem_wen),        32'(v.e_mwen));
    chk($sformatf("row%0d mem_addr", i),       bus.mem_addr,            v.e_maddr);
    chk($sformatf("row%0d mem_wdata", i),      bus.mem_wdata,           v.e_mwdata);
    chk($sformatf("row%0d mem_wmask", i),      32'(bus.mem_wmask),      32'(v.e_mwmask));
    chk($sformatf("row%0d mem_rmask", i),      32'(bus.mem_rmask),      32'(v.e_mrmask));
    chk($sformatf("row%0d ifu_resp_valid", i), 32'(bus.ifu_resp_valid), 32'(v.e_ifu_rv));
    chk($sformatf("row%0d ifu_rdata", i),      bus.ifu_rdata,           v.e_ifu_rd);
    chk($sformatf("row%0d lsu_resp_valid", i), 32'(bus.lsu_resp_valid), 32'(v.e_lsu_rv));
    chk($sformatf("row%0d lsu_rdata", i),      bus.lsu_rdata,           v.e_lsu_rd);
    chk($sformatf("row%0d busy", i),           32'(bus.busy),           32'(v.e_busy));
    chk($sformatf("row%0d owner_lsu", i),      32'(bus.owner_lsu),      32'(v.e_own));
    chk($sformatf("row%0d ifu_resp_err", i),   32'(bus.ifu_resp_err),   32'h0);
    chk($sformatf("row%0d lsu_resp_err", i),   32'(bus.lsu_resp_err),   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t w;
    // IFU fetch, zero-wait memory
    tbl.push_back('{1'b1, A1, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b1, 1'b1, 32'h0000_0413,
                   1'b0, 1'b0, 1'b1, 1'b0, A1, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, A1, 32'h0, 8'h00, 3'h7, 1'b1, 32'h0000_0413, 1'b0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, A1, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0000_0413, 1'b0, 32'h0, 1'b0, 1'b0});
    // Simultaneous requests: LSU load first, IFU held until next IDLE
    tbl.push_back('{1'b1, A2, 1'b1, 1'b0, AL, 32'h0, 8'h00, 3'h2, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 1'b0, A1, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0000_0413, 1'b0, 32'h0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, A2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b1, 1'b1, 32'h1122_3344,
                   1'b0, 1'b0, 1'b1, 1'b0, AL, 32'h0, 8'h00, 3'h2, 1'b0, 32'h0000_0413, 1'b0, 32'h0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, A2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, AL, 32'h0, 8'h00, 3'h2, 1'b0, 32'h0000_0413, 1'b1, 32'h1122_3344, 1'b1, 1'b1});
    tbl.push_back('{1'b1, A2, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 1'b0, AL, 32'h0, 8'h00, 3'h2, 1'b0, 32'h0000_0413, 1'b0, 32'h1122_3344, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b1, 1'b1, 32'h0010_0093,
                   1'b0, 1'b0, 1'b1, 1'b0, A2, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0000_0413, 1'b0, 32'h1122_3344, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, A2, 32'h0, 8'h00, 3'h7, 1'b1, 32'h0010_0093, 1'b0, 32'h1122_3344, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, A2, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0010_0093, 1'b0, 32'h1122_3344, 1'b0, 1'b0});
    // LSU store, memory acks after 5 silent WAIT cycles
    tbl.push_back('{1'b0, 32'h0, 1'b1, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b1, 1'b0, 1'b0, A2, 32'h0, 8'h00, 3'h7, 1'b0, 32'h0010_0093, 1'b0, 32'h1122_3344, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b1, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 32'h0010_0093, 1'b0, 32'h1122_3344, 1'b1, 1'b1});
    w = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 32'h0010_0093, 1'b0, 32'h1122_3344, 1'b1, 1'b1};
    for (int k = 0; k < 5; k++) tbl.push_back(w);
    w.mresp = 1'b1; w.mrdata = 32'hCAFE_F00D;
    tbl.push_back(w);
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 32'h0010_0093, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1});
    // Stray memory response while IDLE must be ignored
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b1, 1'b1, 32'h0000_0BAD,
                   1'b0, 1'b0, 1'b0, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 32'h0010_0093, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, AS, 32'hDEAD_BEEF, 8'h0F, 3'h0, 1'b0, 32'h0010_0093, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1});

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset busy",      32'(bus.busy),          32'h0);
    chk("reset owner_lsu", 32'(bus.owner_lsu),     32'h0);
    chk("reset mem_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("reset mem_addr",  bus.mem_addr,           32'h0);
    chk("reset ifu_rdata", bus.ifu_rdata,          32'h0);
    chk("reset lsu_rdata", bus.lsu_rdata,          32'h0);

    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      check_vec(i, tbl[i]);
      step();
    end
    clear_inputs();

    // mem_req_ready stalled 3 cycles while LSU waits with valid held
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0010;
    #1; chk("stall ifu_ready", 32'(bus.ifu_req_ready), 32'h1);
    step();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_3000; bus.lsu_rmask = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d mem_valid", k), 32'(bus.mem_req_valid), 32'h1);
      chk($sformatf("stall%0d mem_addr", k),  bus.mem_addr,           32'h8000_0010);
      chk($sformatf("stall%0d busy", k),      32'(bus.busy),          32'h1);
      chk($sformatf("stall%0d lsu_ready", k), 32'(bus.lsu_req_ready), 32'h0);
      step();
    end
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h55;
    #1; chk("stall accept mem_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("stall accept lsu_ready", 32'(bus.lsu_req_ready), 32'h0);
    step();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    #1; chk("stall ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'h1);
    chk("stall ifu_rdata", bus.ifu_rdata, 32'h55);
    chk("stall resp lsu_ready", 32'(bus.lsu_req_ready), 32'h0);
    step();
    #1; chk("held lsu granted", 32'(bus.lsu_req_ready), 32'h1);
    step();
    bus.lsu_req_valid = 1'b0;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h66;
    #1; chk("held mem_addr", bus.mem_addr, 32'h8000_3000);
    chk("held mem_rmask", 32'(bus.mem_rmask), 32'h1);
    chk("held owner_lsu", 32'(bus.owner_lsu), 32'h1);
    step();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    #1; chk("held lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'h1);
    chk("held lsu_rdata", bus.lsu_rdata, 32'h66);
    chk("held ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'h0);
    step();
    #1; chk("held done busy", 32'(bus.busy), 32'h0);

    // Reset while in WAIT discards the transaction
    bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1; bus.lsu_addr = 32'h8000_4000;
    bus.lsu_wdata = 32'h1234_5678; bus.lsu_wmask = 8'hFF;
    #1; chk("rstw lsu_ready", 32'(bus.lsu_req_ready), 32'h1);
    step();
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    #1; chk("rstw mem_valid", 32'(bus.mem_req_valid), 32'h1);
    step();
    bus.mem_req_ready = 1'b0;
    #1; chk("rstw wait busy", 32'(bus.busy), 32'h1);
    chk("rstw wait mem_valid", 32'(bus.mem_req_valid), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h99;
    #1;
    chk("rstw busy",      32'(bus.busy),          32'h0);
    chk("rstw owner_lsu", 32'(bus.owner_lsu),     32'h0);
    chk("rstw mem_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rstw mem_wen",   32'(bus.mem_wen),       32'h0);
    chk("rstw mem_addr",  bus.mem_addr,           32'h0);
    chk("rstw mem_wdata", bus.mem_wdata,          32'h0);
    chk("rstw ifu_rdata", bus.ifu_rdata,          32'h0);
    chk("rstw lsu_rdata", bus.lsu_rdata,          32'h0);
    step();
    bus.mem_resp_valid = 1'b0;
    #1; chk("rstw late lsu_resp", 32'(bus.lsu_resp_valid), 32'h0);
    chk("rstw late ifu_resp", 32'(bus.ifu_resp_valid), 32'h0);
    step();
    #1; chk("rstw late2 lsu_resp", 32'(bus.lsu_resp_valid), 32'h0);

    // Silent memory: abort with error under the timeout build, hang otherwise
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0018;
    #1; step();
    bus.ifu_req_valid = 1'b0; bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h77;
    #1; step();
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    #1; chk("pre-to ifu_rdata", bus.ifu_rdata, 32'h77);
    step();
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0020;
    #1; chk("to ifu_ready", 32'(bus.ifu_req_ready), 32'h1);
    step();
    bus.ifu_req_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < int'(TO); k++) begin
      #1;
      chk($sformatf("to req%0d mem_valid", k), 32'(bus.mem_req_valid),  32'h1);
      chk($sformatf("to req%0d resp", k),      32'(bus.ifu_resp_valid), 32'h0);
      step();
    end
    #1;
    chk("to ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'h1);
    chk("to ifu_resp_err",   32'(bus.ifu_resp_err),   32'h1);
    chk("to ifu_rdata",      bus.ifu_rdata,           32'h0);
    chk("to mem_valid",      32'(bus.mem_req_valid),  32'h0);
    chk("to lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'h0);
    step();
    #1;
    chk("to after busy", 32'(bus.busy),         32'h0);
    chk("to after err",  32'(bus.ifu_resp_err), 32'h0);
`else
    for (int k = 0; k < 40; k++) begin
      #1;
      chk($sformatf("hang%0d busy", k), 32'(bus.busy),           32'h1);
      chk($sformatf("hang%0d resp", k), 32'(bus.ifu_resp_valid), 32'h0);
      chk($sformatf("hang%0d err", k),  32'(bus.ifu_resp_err),   32'h0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1; chk("hang reset busy", 32'(bus.busy), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
